// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer for a 16-bit combinational ALU: reads operands from an internal
// register file, drives one-hot selects and operand buses, and writes bus3 back to the file.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic [3:0]       i_opcode,
  input  logic [AW-1:0]    i_rd,
  input  logic [AW-1:0]    i_rs1,
  input  logic [AW-1:0]    i_rs2,
  input  logic             i_imm_en,
  input  logic [WIDTH-1:0] i_imm,
  output logic             o_passthrough,
  output logic             o_add,
  output logic             o_sub,
  output logic             o_shr,
  output logic             o_shl,
  output logic             o_band,
  output logic             o_bor,
  output logic             o_bxor,
  output logic             o_bnegate,
  output logic [WIDTH-1:0] o_bus1,
  output logic [WIDTH-1:0] o_bus2,
  input  logic [WIDTH-1:0] i_bus3,
  output logic             o_wb_valid,
  output logic [AW-1:0]    o_wb_addr,
  output logic [WIDTH-1:0] o_wb_data,
  output logic             o_zero_flag,
  output logic             o_illegal_op,
  input  logic [AW-1:0]    i_dbg_addr,
  output logic [WIDTH-1:0] o_dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_legal;
  logic [8:0]       w_sel;
  logic [3:0]       r_opcode;
  logic [AW-1:0]    r_rd;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_wb_valid;
  logic [AW-1:0]    r_wb_addr;
  logic [WIDTH-1:0] r_wb_data;
  logic             r_zero_flag;
  logic             r_illegal_op;

  assign w_legal = (i_opcode <= 4'd8);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Select bit index equals the opcode, so a one-hot shift decodes all nine ops.
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_sel         = '0;
    o_instr_ready = 1'b0;
    o_bus1        = '0;
    o_bus2        = '0;
    case (r_state)
      S_IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) begin
          w_accept = 1'b1;
          if (w_legal) w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_sel  = 9'b1 << r_opcode;
        o_bus1 = r_op_a;
        o_bus2 = r_op_b;
        w_next = S_WB;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign {o_shl, o_shr, o_bnegate, o_bxor, o_bor, o_band, o_sub, o_add, o_passthrough} = w_sel;

  // Writeback is registered at the WB exit edge so a reset during WB suppresses it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_opcode     <= '0;
      r_rd         <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_zero_flag  <= 1'b0;
      r_illegal_op <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_illegal_op <= 1'b0;
      if (w_accept) begin
        if (w_legal) begin
          r_opcode <= i_opcode;
          r_rd     <= i_rd;
          r_op_a   <= r_regs[i_rs1];
          r_op_b   <= i_imm_en ? i_imm : r_regs[i_rs2];
        end else begin
          r_illegal_op <= 1'b1;
        end
      end
      if (r_state == S_EXEC) r_result <= i_bus3;
      if (r_state == S_WB) begin
        r_regs[r_rd] <= r_result;
        r_wb_valid   <= 1'b1;
        r_wb_addr    <= r_rd;
        r_wb_data    <= r_result;
        r_zero_flag  <= (r_result == '0);
      end
    end
  end

  assign o_wb_valid   = r_wb_valid;
  assign o_wb_addr    = r_wb_addr;
  assign o_wb_data    = r_wb_data;
  assign o_zero_flag  = r_zero_flag;
  assign o_illegal_op = r_illegal_op;
  assign o_dbg_data   = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed ops against a behavioural ALU, with a
// monitor popping expected writebacks whenever wb_valid is seen.
module tb_alu_op_sequencer;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       opcode;
  logic [AW-1:0]    rd, rs1, rs2;
  logic             imm_en;
  logic [WIDTH-1:0] imm;
  logic             passthrough, add, sub, shr, shl, band, bor, bxor, bnegate;
  logic [WIDTH-1:0] bus1, bus2, bus3;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             zero_flag;
  logic             illegal_op;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic [8:0]       sel;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wb_t;

  wb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_imm_en(imm_en), .i_imm(imm),
    .o_passthrough(passthrough), .o_add(add), .o_sub(sub), .o_shr(shr), .o_shl(shl),
    .o_band(band), .o_bor(bor), .o_bxor(bxor), .o_bnegate(bnegate),
    .o_bus1(bus1), .o_bus2(bus2), .i_bus3(bus3),
    .o_wb_valid(wb_valid), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
    .o_zero_flag(zero_flag), .o_illegal_op(illegal_op),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  assign sel = {shl, shr, bnegate, bxor, bor, band, sub, add, passthrough};

  // Behavioural ALU; drives a marker value when no select is active.
  always_comb begin
    bus3 = 16'hDEAD;
    if (passthrough)  bus3 = bus2;
    else if (add)     bus3 = bus1 + bus2;
    else if (sub)     bus3 = bus1 - bus2;
    else if (band)    bus3 = bus1 & bus2;
    else if (bor)     bus3 = bus1 | bus2;
    else if (bxor)    bus3 = bus1 ^ bus2;
    else if (bnegate) bus3 = ~bus1;
    else if (shr)     bus3 = bus1 >> bus2;
    else if (shl)     bus3 = bus1 << bus2;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_valid) begin
      checkOutput("wb_vs_illegal", {31'b0, illegal_op}, 32'd0);
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_wb: got addr %0d data %0h expected no writeback", wb_addr, wb_data);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        checkOutput("wb_addr", {29'b0, wb_addr}, {29'b0, e.addr});
        checkOutput("wb_data", {16'b0, wb_data}, {16'b0, e.data});
        checkOutput("zero_flag", {31'b0, zero_flag}, {31'b0, (e.data == 16'h0)});
      end
    end
  end

  task automatic checkReg(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    dbg_addr = a;
    #1;
    checkOutput($sformatf("dbg_r%0d", a), {16'b0, dbg_data}, {16'b0, exp});
  endtask

  task automatic waitAccept();
    int n = 0;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                               input logic [AW-1:0] s2, input logic ie, input logic [WIDTH-1:0] im,
                               input logic [WIDTH-1:0] expB1, input logic [WIDTH-1:0] expB2,
                               input logic [WIDTH-1:0] expRes);
    wb_t e;
    logic [8:0] expSel;
    e.addr = d;
    e.data = expRes;
    sbq.push_back(e);
    expSel = 9'b1 << op;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm_en = ie; imm = im;
    waitAccept();
    @(negedge clk);
    checkOutput("exec_sel", {23'b0, sel}, {23'b0, expSel});
    checkOutput("exec_bus1", {16'b0, bus1}, {16'b0, expB1});
    checkOutput("exec_bus2", {16'b0, bus2}, {16'b0, expB2});
    checkOutput("exec_ready", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("wb_state_sel", {23'b0, sel}, 32'd0);
    checkOutput("wb_early", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    checkOutput("wb_timing", {31'b0, wb_valid}, 32'd1);
    checkReg(d, expRes);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    imm_en = 1'b0; imm = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NREGS; i++) checkReg(AW'(i), 16'h0000);
    checkOutput("rst_ready", {31'b0, instr_ready}, 32'd1);
    checkOutput("rst_sel", {23'b0, sel}, 32'd0);
    checkOutput("rst_bus1", {16'b0, bus1}, 32'd0);
    checkOutput("rst_bus2", {16'b0, bus2}, 32'd0);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_zero", {31'b0, zero_flag}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal_op}, 32'd0);

    //            op    rd    rs1   rs2   ie    imm       bus1      bus2      result
    applyStimulus(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'h1234);
    applyStimulus(4'd1, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001, 16'h1234, 16'h0001, 16'h1235);
    applyStimulus(4'd2, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF);
    checkOutput("zero_after_sub", {31'b0, zero_flag}, 32'd0);
    applyStimulus(4'd5, 3'd4, 3'd3, 3'd3, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);
    checkOutput("zero_after_xor", {31'b0, zero_flag}, 32'd1);
    applyStimulus(4'd8, 3'd5, 3'd2, 3'd0, 1'b1, 16'h0004, 16'h1235, 16'h0004, 16'h2350);
    applyStimulus(4'd7, 3'd6, 3'd2, 3'd0, 1'b1, 16'h0010, 16'h1235, 16'h0010, 16'h0000);
    applyStimulus(4'd6, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    opcode = 4'd12; rd = 3'd1; rs1 = 3'd2; rs2 = 3'd3; imm_en = 1'b1; imm = 16'h5555;
    waitAccept();
    @(negedge clk);
    checkOutput("illegal_pulse", {31'b0, illegal_op}, 32'd1);
    checkOutput("illegal_ready", {31'b0, instr_ready}, 32'd1);
    checkOutput("illegal_sel", {23'b0, sel}, 32'd0);
    @(negedge clk);
    checkOutput("illegal_clear", {31'b0, illegal_op}, 32'd0);
    checkReg(3'd1, 16'h1234);
    checkReg(3'd7, 16'hFFFF);

    applyStimulus(4'd3, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h1234, 16'h1235, 16'h1234);
    applyStimulus(4'd4, 3'd3, 3'd5, 3'd1, 1'b0, 16'h0000, 16'h2350, 16'h1234, 16'h3374);
    applyStimulus(4'd1, 3'd6, 3'd7, 3'd0, 1'b1, 16'h0002, 16'hFFFF, 16'h0002, 16'h0001);

    // Reset while the ADD sits in EXEC: no writeback may ever appear for it.
    opcode = 4'd1; rd = 3'd1; rs1 = 3'd1; rs2 = 3'd0; imm_en = 1'b1; imm = 16'h0001;
    waitAccept();
    @(negedge clk);
    checkOutput("abort_exec_add", {31'b0, add}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_no_wb", {31'b0, wb_valid}, 32'd0);
    end
    checkOutput("abort_ready", {31'b0, instr_ready}, 32'd1);
    checkOutput("abort_sel", {23'b0, sel}, 32'd0);
    checkReg(3'd1, 16'h0000);
    checkReg(3'd3, 16'h0000);
    checkOutput("sb_empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
